// File: rtl/postoffice_send_scheduler_pkg.sv
// postoffice_send_scheduler_pkg: shared types for the post office send path.
package postoffice_send_scheduler_pkg;
    localparam int PO_NUM_DEST = 4;
    localparam int PO_DEST_W   = $clog2(PO_NUM_DEST);

    typedef logic [PO_DEST_W-1:0] postoffice_dest_t;

    typedef struct packed {
        postoffice_dest_t destination;
        logic [15:0]      payload;
    } send_queue_data_t;

    typedef enum logic [1:0] {IDLE, BLOCKED, SEND} postoffice_sched_state_e;
endpackage

// File: rtl/postoffice_send_scheduler_credit_counter_bank.sv
// credit_counter_bank: per-destination saturating credit counters.
// Refunds are OR-merged with returns, so one destination gains at most one credit per cycle.
module credit_counter_bank #(
    parameter int NUM_DEST = 4,
    parameter int CREDITS  = 2,
    parameter int DEST_W   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dec,
    input  logic [DEST_W-1:0]   dec_dest,
    input  logic                inc,
    input  logic [DEST_W-1:0]   inc_dest,
    input  logic                refund,
    input  logic [DEST_W-1:0]   refund_dest,
    output logic [NUM_DEST-1:0] nonzero,
    output logic                overflow
);
    localparam int CW = $clog2(CREDITS + 1);

    logic [CW-1:0]       count [NUM_DEST];
    logic [NUM_DEST-1:0] hit_max;

    for (genvar g = 0; g < NUM_DEST; g++) begin : g_cnt
        logic inc_i, dec_i, at_max;
        assign inc_i      = (inc && inc_dest == DEST_W'(g)) || (refund && refund_dest == DEST_W'(g));
        assign dec_i      = dec && dec_dest == DEST_W'(g);
        assign at_max     = count[g] == CW'(CREDITS);
        assign hit_max[g] = inc_i & ~dec_i & at_max;
        assign nonzero[g] = count[g] != '0;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                count[g] <= CW'(CREDITS);
            else if (inc_i && !dec_i && !at_max)
                count[g] <= count[g] + CW'(1);
            else if (dec_i && !inc_i)
                count[g] <= count[g] - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (|hit_max)
            overflow <= 1'b1;
    end
endmodule

// File: rtl/postoffice_send_scheduler.sv
// postoffice_send_scheduler: credit-gated, in-order hand-off from the send queue
// to a one-entry registered network output stage.
module postoffice_send_scheduler
    import postoffice_send_scheduler_pkg::*;
#(
    parameter int NUM_DEST = PO_NUM_DEST,
    parameter int CREDITS  = 2,
    parameter int DEST_W   = PO_DEST_W,
    parameter int STALL_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               send_queue_postoffice_valid,
    output logic               postoffice_send_queue_ready,
    input  send_queue_data_t   send_queue_postoffice_data,
    output logic               postoffice_network_valid,
    input  logic               network_postoffice_ready,
    output send_queue_data_t   postoffice_network_data,
    input  logic               network_postoffice_credit_valid,
    input  logic [DEST_W-1:0]  network_postoffice_credit_dest,
    output logic               postoffice_credit_overflow,
    output logic [STALL_W-1:0] postoffice_stall_cycles
);
    postoffice_sched_state_e state, state_nx;
    logic [NUM_DEST-1:0] nonzero;
    postoffice_dest_t    head_dest;
    logic                head_ok, accept, refund;

    assign head_dest = send_queue_postoffice_data.destination;
    assign head_ok   = nonzero[head_dest];
    // Registered credits only: a same-cycle return cannot raise ready.
    assign accept    = send_queue_postoffice_valid & head_ok &
                       (state != SEND | network_postoffice_ready) & ~flush;
    assign refund    = flush & (state == SEND) & ~network_postoffice_ready;

    assign postoffice_send_queue_ready = accept;
    assign postoffice_network_valid    = state == SEND;

    credit_counter_bank #(
        .NUM_DEST(NUM_DEST),
        .CREDITS (CREDITS),
        .DEST_W  (DEST_W)
    ) u_credits (
        .clk        (clk),
        .rst_n      (rst_n),
        .dec        (accept),
        .dec_dest   (head_dest),
        .inc        (network_postoffice_credit_valid),
        .inc_dest   (network_postoffice_credit_dest),
        .refund     (refund),
        .refund_dest(postoffice_network_data.destination),
        .nonzero    (nonzero),
        .overflow   (postoffice_credit_overflow)
    );

    always_comb begin
        state_nx = flush                                       ? IDLE    :
                   accept                                      ? SEND    :
                   (state == SEND && !network_postoffice_ready) ? SEND    :
                   (send_queue_postoffice_valid && !head_ok)   ? BLOCKED : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                   <= IDLE;
            postoffice_network_data <= '0;
            postoffice_stall_cycles <= '0;
        end else begin
            state <= state_nx;
            if (flush)
                postoffice_network_data <= '0;
            else if (accept)
                postoffice_network_data <= send_queue_postoffice_data;
            if (state == BLOCKED && postoffice_stall_cycles != '1)
                postoffice_stall_cycles <= postoffice_stall_cycles + STALL_W'(1);
        end
    end
endmodule

// File: tb/tb_postoffice_send_scheduler.sv
// tb_postoffice_send_scheduler: directed checks of credit gating, back-pressure,
// flush refund, overflow and asynchronous reset.
module tb_postoffice_send_scheduler;
    import postoffice_send_scheduler_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             sq_valid = 1'b0;
    logic             sq_ready;
    send_queue_data_t sq_data = '0;
    logic             net_valid;
    logic             net_ready = 1'b1;
    send_queue_data_t net_data;
    logic             cr_valid = 1'b0;
    logic [1:0]       cr_dest = '0;
    logic             overflow;
    logic [31:0]      stall;

    int n_cmp = 0;
    int n_fail = 0;
    send_queue_data_t q[$];

    always #5 clk = ~clk;

    postoffice_send_scheduler dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .flush                          (flush),
        .send_queue_postoffice_valid    (sq_valid),
        .postoffice_send_queue_ready    (sq_ready),
        .send_queue_postoffice_data     (sq_data),
        .postoffice_network_valid       (net_valid),
        .network_postoffice_ready       (net_ready),
        .postoffice_network_data        (net_data),
        .network_postoffice_credit_valid(cr_valid),
        .network_postoffice_credit_dest (cr_dest),
        .postoffice_credit_overflow     (overflow),
        .postoffice_stall_cycles        (stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        sq_valid = q.size() != 0;
        sq_data  = sq_valid ? q[0] : '0;
        #1;
    endtask

    task automatic push(input logic [1:0] d, input logic [15:0] p);
        send_queue_data_t e;
        e.destination = d;
        e.payload     = p;
        q.push_back(e);
        refresh();
    endtask

    task automatic tick();
        logic pop;
        pop = sq_valid & sq_ready;
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        refresh();
    endtask

    task automatic give_credit(input logic [1:0] d, input int n);
        cr_valid = 1'b1;
        cr_dest  = d;
        repeat (n) tick();
        cr_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_valid", 32'(net_valid), 0);
        check("rst_data", 32'(net_data), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_stall", stall, 0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_credit0", 32'(dut.u_credits.count[0]), 2);
        check("rst_credit3", 32'(dut.u_credits.count[3]), 2);

        // Three entries to dest 1; the third runs out of credit.
        push(1, 16'h11); push(1, 16'h12); push(1, 16'h13);
        check("t1_ready0", 32'(sq_ready), 1);
        tick();
        check("t1_valid1", 32'(net_valid), 1);
        check("t1_data1", 32'(net_data), {2'd1, 16'h11});
        tick();
        check("t1_data2", 32'(net_data), {2'd1, 16'h12});
        check("t1_credit1_zero", 32'(dut.u_credits.count[1]), 0);
        check("t1_ready_nocredit", 32'(sq_ready), 0);
        tick();
        check("t1_blocked", 32'(dut.state), 32'(BLOCKED));
        check("t1_valid_blocked", 32'(net_valid), 0);
        check("t1_stall0", stall, 0);
        tick(); tick();
        check("t1_stall2", stall, 2);
        cr_valid = 1'b1; cr_dest = 1;
        check("t1_ready_same_cycle", 32'(sq_ready), 0);
        tick();
        cr_valid = 1'b0;
        check("t1_ready_T1", 32'(sq_ready), 1);
        check("t1_valid_T1", 32'(net_valid), 0);
        tick();
        check("t1_valid_T2", 32'(net_valid), 1);
        check("t1_data3", 32'(net_data), {2'd1, 16'h13});
        check("t1_stall4", stall, 4);
        tick();
        check("t1_idle", 32'(dut.state), 32'(IDLE));
        give_credit(1, 2);
        check("t1_credit1_back", 32'(dut.u_credits.count[1]), 2);

        // Back-pressure for five cycles, then in-order drain.
        net_ready = 1'b0;
        push(0, 16'h21); push(2, 16'h22); push(0, 16'h23);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 32'(net_valid), 1);
            check("t2_hold_data", 32'(net_data), {2'd0, 16'h21});
            check("t2_hold_ready", 32'(sq_ready), 0);
            tick();
        end
        net_ready = 1'b1;
        #1;
        tick();
        check("t2_data_22", 32'(net_data), {2'd2, 16'h22});
        tick();
        check("t2_data_23", 32'(net_data), {2'd0, 16'h23});
        tick();
        check("t2_drained", 32'(net_valid), 0);
        check("t2_credit0", 32'(dut.u_credits.count[0]), 0);
        check("t2_credit2", 32'(dut.u_credits.count[2]), 1);
        give_credit(0, 2);
        give_credit(2, 1);

        // Consume and return on dest 3 in the same cycle.
        push(3, 16'h31);
        tick(); tick();
        check("t3_credit3_one", 32'(dut.u_credits.count[3]), 1);
        push(3, 16'h32);
        cr_valid = 1'b1; cr_dest = 3;
        tick();
        cr_valid = 1'b0;
        check("t3_credit3_net0", 32'(dut.u_credits.count[3]), 1);
        check("t3_no_overflow", 32'(overflow), 0);
        check("t3_data", 32'(net_data), {2'd3, 16'h32});
        tick();
        give_credit(3, 1);

        // Return to a full counter.
        give_credit(2, 1);
        check("t4_credit2_sat", 32'(dut.u_credits.count[2]), 2);
        check("t4_overflow", 32'(overflow), 1);
        tick(); tick();
        check("t4_overflow_sticky", 32'(overflow), 1);

        // Flush while held with network not ready: refund.
        net_ready = 1'b0;
        push(1, 16'h41);
        tick(); tick();
        check("t5_held", 32'(net_data), {2'd1, 16'h41});
        check("t5_credit1_one", 32'(dut.u_credits.count[1]), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_flush_valid", 32'(net_valid), 0);
        check("t5_flush_state", 32'(dut.state), 32'(IDLE));
        check("t5_flush_data", 32'(net_data), 0);
        check("t5_refund", 32'(dut.u_credits.count[1]), 2);

        // Flush in the hand-over cycle: no refund, no accept.
        push(1, 16'h43);
        tick();
        push(1, 16'h44);
        net_ready = 1'b1; flush = 1'b1;
        #1;
        check("t5_ready_flush", 32'(sq_ready), 0);
        tick();
        flush = 1'b0;
        q.delete();
        refresh();
        check("t5_handed_valid", 32'(net_valid), 0);
        check("t5_no_refund", 32'(dut.u_credits.count[1]), 1);
        give_credit(1, 1);

        // Asynchronous reset mid-SEND.
        net_ready = 1'b0;
        push(2, 16'h61);
        tick();
        check("t6_pre_valid", 32'(net_valid), 1);
        check("t6_pre_stall", stall, 4);
        check("t6_pre_credit2", 32'(dut.u_credits.count[2]), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(net_valid), 0);
        check("t6_rst_credit2", 32'(dut.u_credits.count[2]), 2);
        check("t6_rst_credit1", 32'(dut.u_credits.count[1]), 2);
        check("t6_rst_stall", stall, 0);
        check("t6_rst_overflow", 32'(overflow), 0);
        check("t6_rst_data", 32'(net_data), 0);
        q.delete();
        refresh();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
